// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready
// handshake, optional two-entry skid buffer, synchronous flush (bubble insert)
// and a saturating stall-cycle counter for performance debug.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ready;

    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [ADDR_W-1:0]  r_main_addr;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [ADDR_W-1:0]  r_skid_addr;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_valid;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic               w_clr_ctrl;

    assign w_valid    = (r_state != ST_EMPTY);
    // With the skid buffer ready_o comes straight from a flop; without it the
    // stage can accept whenever the head is leaving or absent.
    assign ready_o    = (SKID != 0) ? r_ready : (!w_valid || ready_i);
    assign w_in_xfer  = valid_i && ready_o;
    assign w_out_xfer = w_valid && ready_i;

    assign valid_o     = w_valid;
    assign ctrl_o      = r_main_ctrl;
    assign rd_addr_o   = r_main_addr;
    assign data_o      = r_main_data;
    assign stall_cnt_o = r_stall_cnt;

    // Next-state and storage-load decode; flush overrides every transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clr_ctrl       = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_clr_ctrl  = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                        w_clr_ctrl  = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_clr_ctrl  = 1'b1;
                end
            endcase
        end
    end

    // State register and registered ready (low exactly while two entries are held).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Main register: loads input or skid contents; control cleared on bubbles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_ctrl <= '0;
            r_main_addr <= '0;
            r_main_data <= '0;
        end else begin
            if (w_clr_ctrl) begin
                r_main_ctrl <= '0;
            end else if (w_load_main_in) begin
                r_main_ctrl <= ctrl_i;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_main_in) begin
                r_main_addr <= rd_addr_i;
                r_main_data <= data_i;
            end else if (w_load_main_skid) begin
                r_main_addr <= r_skid_addr;
                r_main_data <= r_skid_data;
            end
        end
    end

    // Skid register: captures the entry accepted while the head is stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_skid_ctrl <= '0;
            r_skid_addr <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= ctrl_i;
            r_skid_addr <= rd_addr_i;
            r_skid_data <= data_i;
        end
    end

    // Saturating count of cycles where the head is valid but not accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_valid && !ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: one skid instance (4-bit stall counter) and one
// single-entry instance, each checked every cycle against a queue-based model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [1:0]  c;
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit done1    = 1'b0;
    bit done2    = 1'b0;

    // ---------------- instance 1: SKID=1, CNT_W=4 ----------------
    logic        rst1 = 1'b1, flush1 = 1'b0, valid_i1 = 1'b0, ready_i1 = 1'b0;
    logic [1:0]  ctrl_i1 = '0;
    logic [4:0]  addr_i1 = '0;
    logic [63:0] data_i1 = '0;
    logic        ready_o1, valid_o1;
    logic [1:0]  ctrl_o1;
    logic [4:0]  addr_o1;
    logic [63:0] data_o1;
    logic [3:0]  cnt_o1;

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_skid (
        .clk_i(clk), .rst_i(rst1), .flush_i(flush1),
        .valid_i(valid_i1), .ready_o(ready_o1),
        .ctrl_i(ctrl_i1), .rd_addr_i(addr_i1), .data_i(data_i1),
        .valid_o(valid_o1), .ready_i(ready_i1),
        .ctrl_o(ctrl_o1), .rd_addr_o(addr_o1), .data_o(data_o1),
        .stall_cnt_o(cnt_o1)
    );

    // ---------------- instance 2: SKID=0, CNT_W=16 ----------------
    logic        rst2 = 1'b1, flush2 = 1'b0, valid_i2 = 1'b0, ready_i2 = 1'b0;
    logic [1:0]  ctrl_i2 = '0;
    logic [4:0]  addr_i2 = '0;
    logic [63:0] data_i2 = '0;
    logic        ready_o2, valid_o2;
    logic [1:0]  ctrl_o2;
    logic [4:0]  addr_o2;
    logic [63:0] data_o2;
    logic [15:0] cnt_o2;

    pipe_stage_reg #(.SKID(0)) u_noskid (
        .clk_i(clk), .rst_i(rst2), .flush_i(flush2),
        .valid_i(valid_i2), .ready_o(ready_o2),
        .ctrl_i(ctrl_i2), .rd_addr_i(addr_i2), .data_i(data_i2),
        .valid_o(valid_o2), .ready_i(ready_i2),
        .ctrl_o(ctrl_o2), .rd_addr_o(addr_o2), .data_o(data_o2),
        .stall_cnt_o(cnt_o2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard / monitor for instance 1 ----------------
    // Model: a FIFO of at most two accepted entries; ready while fewer than two held.
    ent_t q1[$];
    int   cnt1 = 0;
    always @(negedge clk) begin : mon_skid
        bit   v, er, in_x, out_x;
        ent_t e;
        if (rst1) begin
            q1.delete();
            cnt1 = 0;
            chk("s_rst_valid", 64'(valid_o1), 64'd0);
            chk("s_rst_ready", 64'(ready_o1), 64'd1);
            chk("s_rst_ctrl",  64'(ctrl_o1),  64'd0);
            chk("s_rst_addr",  64'(addr_o1),  64'd0);
            chk("s_rst_data",  data_o1,       64'd0);
            chk("s_rst_cnt",   64'(cnt_o1),   64'd0);
        end else begin
            v  = (q1.size() > 0);
            er = (q1.size() < 2);
            chk("s_valid", 64'(valid_o1), 64'(v));
            chk("s_ready", 64'(ready_o1), 64'(er));
            chk("s_cnt",   64'(cnt_o1),   64'(cnt1));
            chk("s_ctrl",  64'(ctrl_o1),  v ? 64'(q1[0].c) : 64'd0);
            if (v) begin
                chk("s_addr", 64'(addr_o1), 64'(q1[0].a));
                chk("s_data", data_o1,      q1[0].d);
            end
            in_x  = valid_i1 && er;
            out_x = v && ready_i1;
            if (flush1) begin
                q1.delete();
            end else begin
                if (out_x) void'(q1.pop_front());
                if (in_x) begin
                    e.c = ctrl_i1; e.a = addr_i1; e.d = data_i1;
                    q1.push_back(e);
                end
            end
            if (v && !ready_i1 && cnt1 < 15) cnt1++;
        end
    end

    // ---------------- scoreboard / monitor for instance 2 ----------------
    ent_t q2[$];
    int   cnt2 = 0;
    always @(negedge clk) begin : mon_noskid
        bit   v, er, in_x, out_x;
        ent_t e;
        if (rst2) begin
            q2.delete();
            cnt2 = 0;
            chk("n_rst_valid", 64'(valid_o2), 64'd0);
            chk("n_rst_ctrl",  64'(ctrl_o2),  64'd0);
            chk("n_rst_data",  data_o2,       64'd0);
            chk("n_rst_cnt",   64'(cnt_o2),   64'd0);
        end else begin
            v  = (q2.size() > 0);
            er = !v || ready_i2;
            chk("n_valid", 64'(valid_o2), 64'(v));
            chk("n_ready", 64'(ready_o2), 64'(er));
            chk("n_cnt",   64'(cnt_o2),   64'(cnt2));
            chk("n_ctrl",  64'(ctrl_o2),  v ? 64'(q2[0].c) : 64'd0);
            if (v) begin
                chk("n_addr", 64'(addr_o2), 64'(q2[0].a));
                chk("n_data", data_o2,      q2[0].d);
            end
            in_x  = valid_i2 && er;
            out_x = v && ready_i2;
            if (flush2) begin
                q2.delete();
            end else begin
                if (out_x) void'(q2.pop_front());
                if (in_x) begin
                    e.c = ctrl_i2; e.a = addr_i2; e.d = data_i2;
                    q2.push_back(e);
                end
            end
            if (v && !ready_i2 && cnt2 < 65535) cnt2++;
        end
    end

    task automatic drive1(input logic v, input logic [63:0] d);
        valid_i1 = v;
        data_i1  = d;
        ctrl_i1  = d[1:0];
        addr_i1  = d[6:2];
    endtask

    // ---------------- stimulus for instance 1 ----------------
    initial begin : stim_skid
        step(); step();
        rst1 = 1'b0;

        // streaming 1..8 at full rate
        ready_i1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive1(1'b1, 64'(i));
            step();
        end
        drive1(1'b0, 64'd0);
        repeat (3) step();

        // backpressure: A shown, B to skid, C withheld, then drain
        drive1(1'b1, 64'hA);
        step();
        drive1(1'b1, 64'hB);
        ready_i1 = 1'b0;
        step();
        drive1(1'b1, 64'hC);
        repeat (4) step();
        ready_i1 = 1'b1;
        step();
        step();
        drive1(1'b0, 64'd0);
        repeat (4) step();

        // flush while two entries are held, with a simultaneous input
        ready_i1 = 1'b0;
        drive1(1'b1, 64'h11);
        step();
        drive1(1'b1, 64'h12);
        step();
        flush1 = 1'b1;
        valid_i1 = 1'b1; data_i1 = 64'hD; ctrl_i1 = 2'b11; addr_i1 = 5'd13;
        step();
        flush1 = 1'b0;
        drive1(1'b0, 64'd0);
        step();
        ready_i1 = 1'b1;
        repeat (3) step();

        // saturation: head valid and stalled for 20 cycles
        ready_i1 = 1'b0;
        drive1(1'b1, 64'h77);
        repeat (20) step();

        // asynchronous reset with two entries held
        rst1 = 1'b1;
        #1;
        chk("s_async_valid", 64'(valid_o1), 64'd0);
        chk("s_async_ctrl",  64'(ctrl_o1),  64'd0);
        chk("s_async_data",  data_o1,       64'd0);
        chk("s_async_cnt",   64'(cnt_o1),   64'd0);
        chk("s_async_ready", 64'(ready_o1), 64'd1);
        step();
        rst1 = 1'b0;
        ready_i1 = 1'b1;
        drive1(1'b1, 64'h55);
        step();
        drive1(1'b0, 64'd0);
        repeat (2) step();

        // random traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            drive1($urandom_range(0, 3) != 0, {$urandom, $urandom});
            ready_i1 = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            flush1   = ($urandom_range(0, 31) == 0);
            step();
        end
        drive1(1'b0, 64'd0);
        flush1   = 1'b0;
        ready_i1 = 1'b1;
        repeat (4) step();
        done1 = 1'b1;
    end

    // ---------------- stimulus for instance 2 ----------------
    initial begin : stim_noskid
        step(); step();
        rst2 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            valid_i2 = ($urandom_range(0, 2) != 0);
            data_i2  = {$urandom, $urandom};
            ctrl_i2  = 2'($urandom_range(0, 3));
            addr_i2  = 5'($urandom_range(0, 31));
            ready_i2 = ($urandom_range(0, 2) != 0);
            flush2   = ($urandom_range(0, 47) == 0);
            step();
        end
        valid_i2 = 1'b0;
        flush2   = 1'b0;
        ready_i2 = 1'b1;
        repeat (4) step();
        done2 = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : summary
        wait (done1 && done2);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the CPU datapath. It carries a control field, a destination-register address and a data payload from one stage to the next. It adds the following over a plain latch:
- valid/ready handshake
- optional two-entry skid buffer, so a registered `ready_o` still gives full throughput
- synchronous flush that inserts a bubble
- saturating stall-cycle counter for performance debug

## Interface
Parameters:
- `DATA_W`, default 64: payload width (e.g. two 32-bit operands: ALU result + memory read data).
- `CTRL_W`, default 2: control field width (e.g. RegWrite, MemtoReg); forced to 0 in bubbles.
- `ADDR_W`, default 5: destination register address width.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `ready_o`; 0 = single entry with combinational `ready_o`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk_i`, in, 1: clock; everything is updated on the rising edge.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `flush_i`, in, 1: synchronous flush; discards all held entries and the same-cycle input.
- `valid_i`, in, 1: upstream entry valid.
- `ready_o`, out, 1: stage can accept an entry.
- `ctrl_i`, in, `CTRL_W`: control field in.
- `rd_addr_i`, in, `ADDR_W`: destination address in.
- `data_i`, in, `DATA_W`: payload in.
- `valid_o`, out, 1: head entry valid.
- `ready_i`, in, 1: downstream accepts the head entry.
- `ctrl_o`, out, `CTRL_W`: head control field; 0 whenever `valid_o` = 0.
- `rd_addr_o`, out, `ADDR_W`: head destination address.
- `data_o`, out, `DATA_W`: head payload.
- `stall_cnt_o`, out, `CNT_W`: count of cycles with `valid_o` & !`ready_i`.

## Operation
- Input transfer: `in_xfer` = `valid_i` & `ready_o`.
- Output transfer: `out_xfer` = `valid_o` & `ready_i`.
- Storage: main register (drives the outputs directly) plus, when `SKID`=1, one skid register.
- States: EMPTY, ONE, TWO. TWO exists only when `SKID`=1.
- EMPTY:
  - `in_xfer` -> ONE; main loads the input.
- ONE:
  - `in_xfer` & `out_xfer` -> ONE; main loads the input.
  - `in_xfer` & !`out_xfer` -> TWO; skid loads the input.
  - `out_xfer` & !`in_xfer` -> EMPTY.
  - Otherwise hold.
- TWO (`ready_o` = 0, so no input can arrive):
  - `out_xfer` -> ONE; main loads the skid contents.
  - Otherwise hold.
- `ready_o`:
  - `SKID`=1: `ready_o` = (state != TWO), driven from a register.
  - `SKID`=0: `ready_o` = !`valid_o` | `ready_i`; ONE with `in_xfer` & !`out_xfer` cannot occur.
- Order is strictly FIFO. Entries are never dropped or duplicated, except on flush.
- Flush has priority over every transfer:
  - Next state is EMPTY; main and skid valid bits clear.
  - `ctrl_o` is forced to 0.
  - A same-cycle `in_xfer` is discarded.
  - `rd_addr_o` and `data_o` keep their last values (don't-care while `valid_o` = 0).
- Bubble rule: any transition to EMPTY also clears the main control field, so `ctrl_o` = 0 whenever `valid_o` = 0.
- Stall counter:
  - +1 on each cycle with `valid_o` & !`ready_i`.
  - Saturates at 2^`CNT_W`-1.
  - Unaffected by flush; cleared only by reset.
- Reset: state EMPTY; every output 0 (`valid_o`, `ctrl_o`, `rd_addr_o`, `data_o`, `stall_cnt_o`); `ready_o` = 1.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing
- Latency: an entry accepted at edge N appears on the outputs after edge N with `valid_o` = 1. Bypass is never combinational.
- Throughput: one entry per cycle while `ready_i` = 1, for both `SKID` settings.
- `SKID`=1: `ready_o` falls one cycle after the first stalled accept and rises the cycle after the drain out of TWO. No combinational path from `ready_i` to `ready_o`.
- `SKID`=0: combinational `ready_i` -> `ready_o` path (single-stage use only).
- Reset deassertion: the first accept can happen at the first rising edge after `rst_i` falls.
- Outputs change only on a clock edge or on reset assertion.

## Test plan
- Reset: assert `rst_i` mid-stream with two entries held -> immediately `valid_o`=0, `ctrl_o`=0, `data_o`=0, `stall_cnt_o`=0, `ready_o`=1.
- Streaming, `SKID`=1, `ready_i`=1: send data 0x1..0x8, one per cycle -> identical sequence on `data_o` one cycle later; `ready_o` never drops.
- Backpressure: stream 0xA, 0xB, 0xC with `ready_i`=0 from the cycle 0xA appears:
  - 0xB is held in skid; `ready_o`=0 on the next cycle; 0xC is withheld upstream.
  - Raise `ready_i` -> outputs 0xA, 0xB, 0xC in order; `stall_cnt_o` equals the stalled cycle count.
- Flush in TWO, with a simultaneous `valid_i` carrying 0xD and `ctrl_i`=2'b11:
  - Next cycle: `valid_o`=0, `ctrl_o`=0, `ready_o`=1; 0xD is never output.
- Saturation: `CNT_W`=4, hold `ready_i`=0 for 20 cycles with `valid_o`=1 -> `stall_cnt_o` stops at 15.
- `SKID`=0: random `valid_i`/`ready_i` -> output order matches input order; `ready_o` = !`valid_o` | `ready_i` every cycle.
